// File: rtl/alu_writeback.sv
// alu_writeback
//   Writeback stage behind the combinational ALU. Captures the ALU result,
//   merges the ALU flags into the architectural FLAGS register (fed back to
//   the ALU's flags_in), then commits the result either to the register file
//   or to memory. Unaligned word stores are split into two byte accesses.
//
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   in_valid / in_ready    handshake from the microcode sequencer
//   alu_out, alu_flags     ALU result and flags_out
//   is_8_bit               byte operation
//   flags_mask             1 = take that FLAGS bit from alu_flags
//   dest                   0 none, 1 register, 2 memory, 3 reserved (none)
//   reg_sel, mem_addr      destination register / byte address
//   flags                  architectural FLAGS
//   reg_wr_*               register file write port
//   mem_*                  memory write bus (word address, byte lanes)
//   complete               one-cycle pulse when a transaction retires
module alu_writeback #(
    parameter logic [15:0] FLAGS_RESET = 16'h0002
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] alu_out,
    input  logic [15:0] alu_flags,
    input  logic        is_8_bit,
    input  logic [15:0] flags_mask,
    input  logic [1:0]  dest,
    input  logic [2:0]  reg_sel,
    input  logic [15:0] mem_addr,
    output logic [15:0] flags,
    output logic        reg_wr_en,
    output logic [2:0]  reg_wr_sel,
    output logic [15:0] reg_wr_val,
    output logic        reg_wr_8_bit,
    output logic        mem_access,
    output logic [14:0] mem_address,
    output logic [15:0] mem_data,
    output logic [1:0]  mem_bytesel,
    input  logic        mem_ack,
    output logic        complete
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REG_WR = 3'd1;
    localparam logic [2:0] S_MEM_LO = 3'd2;
    localparam logic [2:0] S_MEM_HI = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    // Bit 1 of FLAGS is hard-wired to 1.
    localparam logic [15:0] FLAGS_FIXED = 16'h0002;

    logic [2:0]  state_q, state_d;
    logic [15:0] flags_q, flags_d;
    logic [15:0] res_q, res_d;
    logic        is8_q, is8_d;
    logic [2:0]  sel_q, sel_d;
    logic [15:0] addr_q, addr_d;

    // Next-state and capture logic
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        res_d   = res_q;
        is8_d   = is8_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    res_d   = alu_out;
                    is8_d   = is_8_bit;
                    sel_d   = reg_sel;
                    addr_d  = mem_addr;
                    flags_d = (flags_q & ~flags_mask) | (alu_flags & flags_mask)
                              | FLAGS_FIXED;
                    case (dest)
                        2'd1:    state_d = S_REG_WR;
                        2'd2:    state_d = S_MEM_LO;
                        default: state_d = S_FIN;
                    endcase
                end
            end
            S_REG_WR: state_d = S_IDLE;
            S_MEM_LO: begin
                if (mem_ack) begin
                    // Only a word store at an odd address needs the second half.
                    state_d = (!is8_q && addr_q[0]) ? S_MEM_HI : S_FIN;
                end
            end
            S_MEM_HI: begin
                if (mem_ack) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            flags_q <= FLAGS_RESET | FLAGS_FIXED;
            res_q   <= '0;
            is8_q   <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            res_q   <= res_d;
            is8_q   <= is8_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
        end
    end

    // Output decode from registered state; everything idles at zero.
    always_comb begin
        in_ready     = (state_q == S_IDLE);
        flags        = flags_q;
        reg_wr_en    = 1'b0;
        reg_wr_sel   = '0;
        reg_wr_val   = '0;
        reg_wr_8_bit = 1'b0;
        mem_access   = 1'b0;
        mem_address  = '0;
        mem_data     = '0;
        mem_bytesel  = '0;
        complete     = 1'b0;
        case (state_q)
            S_REG_WR: begin
                reg_wr_en    = 1'b1;
                reg_wr_sel   = sel_q;
                reg_wr_val   = is8_q ? {8'h00, res_q[7:0]} : res_q;
                reg_wr_8_bit = is8_q;
                complete     = 1'b1;
            end
            S_MEM_LO: begin
                mem_access  = 1'b1;
                mem_address = addr_q[15:1];
                if (addr_q[0]) begin
                    // Odd address: low result byte goes on the high lane,
                    // for both byte stores and the first half of a word store.
                    mem_bytesel = 2'b10;
                    mem_data    = {res_q[7:0], 8'h00};
                end else if (is8_q) begin
                    mem_bytesel = 2'b01;
                    mem_data    = {8'h00, res_q[7:0]};
                end else begin
                    mem_bytesel = 2'b11;
                    mem_data    = res_q;
                end
            end
            S_MEM_HI: begin
                mem_access  = 1'b1;
                // Entered only with an odd address, so (addr+1)[15:1] is
                // addr[15:1]+1; 15-bit wrap takes 16'hFFFF to word 0.
                mem_address = addr_q[15:1] + 15'd1;
                mem_bytesel = 2'b01;
                mem_data    = {8'h00, res_q[15:8]};
            end
            S_FIN: complete = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_out;
    logic [15:0] alu_flags;
    logic        is_8_bit;
    logic [15:0] flags_mask;
    logic [1:0]  dest;
    logic [2:0]  reg_sel;
    logic [15:0] mem_addr;
    logic [15:0] flags;
    logic        reg_wr_en;
    logic [2:0]  reg_wr_sel;
    logic [15:0] reg_wr_val;
    logic        reg_wr_8_bit;
    logic        mem_access;
    logic [14:0] mem_address;
    logic [15:0] mem_data;
    logic [1:0]  mem_bytesel;
    logic        mem_ack;
    logic        complete;

    int total;
    int bad;

    alu_writeback #(.FLAGS_RESET(16'h0002)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .is_8_bit     (is_8_bit),
        .flags_mask   (flags_mask),
        .dest         (dest),
        .reg_sel      (reg_sel),
        .mem_addr     (mem_addr),
        .flags        (flags),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_sel   (reg_wr_sel),
        .reg_wr_val   (reg_wr_val),
        .reg_wr_8_bit (reg_wr_8_bit),
        .mem_access   (mem_access),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_bytesel  (mem_bytesel),
        .mem_ack      (mem_ack),
        .complete     (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] d, input logic [15:0] r, input logic b8,
                         input logic [15:0] a, input logic [15:0] fl,
                         input logic [15:0] mk);
        dest = d; alu_out = r; is_8_bit = b8; mem_addr = a;
        alu_flags = fl; flags_mask = mk; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total++; if (flags !== 16'h0002) begin bad++; $display("FAIL rst_flags got=%h exp=0002", flags); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
        total++; if ({reg_wr_en, mem_access, complete} !== 3'b000) begin bad++; $display("FAIL rst_strobes got=%b exp=000", {reg_wr_en, mem_access, complete}); end
        total++; if (mem_bytesel !== 2'b00 || mem_data !== 16'h0 || reg_wr_val !== 16'h0) begin bad++; $display("FAIL rst_data got=%b %h %h exp=0", mem_bytesel, mem_data, reg_wr_val); end
        issue(2'd0, 16'h5555, 1'b0, 16'h0000, 16'hFFFF, 16'h0001);
        total++; if (flags !== 16'h0003) begin bad++; $display("FAIL flags_merge got=%h exp=0003", flags); end
        total++; if (complete !== 1'b1) begin bad++; $display("FAIL none_complete got=%b exp=1", complete); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL none_busy got=%b exp=0", in_ready); end
        total++; if (reg_wr_en !== 1'b0 || mem_access !== 1'b0) begin bad++; $display("FAIL none_strobes got=%b%b exp=00", reg_wr_en, mem_access); end
        tick();
        total++; if (complete !== 1'b0) begin bad++; $display("FAIL none_pulse_len got=%b exp=0", complete); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL none_idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_reg_write();
        reg_sel = 3'd3;
        issue(2'd1, 16'hABCD, 1'b1, 16'h0000, 16'h0000, 16'h0000);
        total++; if (reg_wr_en !== 1'b1 || complete !== 1'b1) begin bad++; $display("FAIL reg8_strobe got=%b%b exp=11", reg_wr_en, complete); end
        total++; if (reg_wr_val !== 16'h00CD) begin bad++; $display("FAIL reg8_val got=%h exp=00CD", reg_wr_val); end
        total++; if (reg_wr_8_bit !== 1'b1 || reg_wr_sel !== 3'd3) begin bad++; $display("FAIL reg8_sel got=%b %0d exp=1 3", reg_wr_8_bit, reg_wr_sel); end
        total++; if (flags !== 16'h0003) begin bad++; $display("FAIL reg8_flags_kept got=%h exp=0003", flags); end
        tick();
        total++; if (reg_wr_en !== 1'b0 || complete !== 1'b0) begin bad++; $display("FAIL reg8_pulse_len got=%b%b exp=00", reg_wr_en, complete); end
        total++; if (in_ready !== 1'b1 || reg_wr_val !== 16'h0) begin bad++; $display("FAIL reg8_idle got=%b %h exp=1 0000", in_ready, reg_wr_val); end
        // Word register write: full value, flags fully replaced (bit 1 forced).
        reg_sel = 3'd5;
        issue(2'd1, 16'h1234, 1'b0, 16'h0000, 16'h0881, 16'hFFFF);
        total++; if (reg_wr_val !== 16'h1234 || reg_wr_8_bit !== 1'b0 || reg_wr_sel !== 3'd5) begin bad++; $display("FAIL reg16 got=%h %b %0d exp=1234 0 5", reg_wr_val, reg_wr_8_bit, reg_wr_sel); end
        total++; if (flags !== 16'h0883) begin bad++; $display("FAIL reg16_flags got=%h exp=0883", flags); end
        tick();
    endtask

    task automatic test_aligned_store();
        issue(2'd2, 16'hBEEF, 1'b0, 16'h1234, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            total++; if (mem_access !== 1'b1 || mem_address !== 15'h091A || mem_bytesel !== 2'b11 || mem_data !== 16'hBEEF || complete !== 1'b0)
                begin bad++; $display("FAIL aln_wait%0d got=%b %h %b %h %b exp=1 091A 11 BEEF 0", i, mem_access, mem_address, mem_bytesel, mem_data, complete); end
            tick();
        end
        mem_ack = 1'b1;
        total++; if (mem_access !== 1'b1 || mem_data !== 16'hBEEF) begin bad++; $display("FAIL aln_ackcyc got=%b %h exp=1 BEEF", mem_access, mem_data); end
        tick();
        mem_ack = 1'b0;
        total++; if (complete !== 1'b1 || mem_access !== 1'b0) begin bad++; $display("FAIL aln_fin got=%b%b exp=10", complete, mem_access); end
        total++; if (flags !== 16'h0883) begin bad++; $display("FAIL aln_flags_kept got=%h exp=0883", flags); end
        tick();
        total++; if (complete !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL aln_idle got=%b%b exp=01", complete, in_ready); end
    endtask

    task automatic unaligned(input logic [15:0] a, input logic [14:0] w0, input logic [14:0] w1);
        issue(2'd2, 16'h1122, 1'b0, a, 16'h0000, 16'h0000);
        // Ack in the very first access cycle.
        mem_ack = 1'b1;
        total++; if (mem_access !== 1'b1 || mem_address !== w0 || mem_bytesel !== 2'b10 || mem_data !== 16'h2200)
            begin bad++; $display("FAIL unal_lo@%h got=%b %h %b %h exp=1 %h 10 2200", a, mem_access, mem_address, mem_bytesel, mem_data, w0); end
        tick();
        mem_ack = 1'b0;
        total++; if (mem_access !== 1'b1 || mem_address !== w1 || mem_bytesel !== 2'b01 || mem_data !== 16'h0011 || complete !== 1'b0)
            begin bad++; $display("FAIL unal_hi@%h got=%b %h %b %h %b exp=1 %h 01 0011 0", a, mem_access, mem_address, mem_bytesel, mem_data, complete, w1); end
        tick();
        total++; if (mem_access !== 1'b1 || mem_address !== w1) begin bad++; $display("FAIL unal_hold@%h got=%b %h exp=1 %h", a, mem_access, mem_address, w1); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if (complete !== 1'b1 || mem_access !== 1'b0) begin bad++; $display("FAIL unal_fin@%h got=%b%b exp=10", a, complete, mem_access); end
        tick();
        total++; if (in_ready !== 1'b1 || complete !== 1'b0) begin bad++; $display("FAIL unal_idle@%h got=%b%b exp=10", a, in_ready, complete); end
    endtask

    task automatic test_unaligned_store();
        unaligned(16'h0101, 15'h0080, 15'h0081);
        unaligned(16'hFFFF, 15'h7FFF, 15'h0000);
    endtask

    task automatic test_odd_byte_store();
        issue(2'd2, 16'h00A5, 1'b1, 16'h0007, 16'h0000, 16'h0000);
        mem_ack = 1'b1;
        total++; if (mem_access !== 1'b1 || mem_address !== 15'h0003 || mem_bytesel !== 2'b10 || mem_data !== 16'hA500)
            begin bad++; $display("FAIL oddb got=%b %h %b %h exp=1 0003 10 A500", mem_access, mem_address, mem_bytesel, mem_data); end
        tick();
        mem_ack = 1'b0;
        total++; if (complete !== 1'b1 || mem_access !== 1'b0) begin bad++; $display("FAIL oddb_single got=%b%b exp=10", complete, mem_access); end
        tick();
        // Even-address byte store uses the low lane.
        issue(2'd2, 16'h7F3C, 1'b1, 16'h0010, 16'h0000, 16'h0000);
        total++; if (mem_address !== 15'h0008 || mem_bytesel !== 2'b01 || mem_data !== 16'h003C)
            begin bad++; $display("FAIL evenb got=%h %b %h exp=0008 01 003C", mem_address, mem_bytesel, mem_data); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        // Stray ack while idle.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if (in_ready !== 1'b1 || mem_access !== 1'b0 || complete !== 1'b0)
            begin bad++; $display("FAIL stray_ack got=%b%b%b exp=100", in_ready, mem_access, complete); end
        tick();
        total++; if (in_ready !== 1'b1 || complete !== 1'b0) begin bad++; $display("FAIL stray_ack2 got=%b%b exp=10", in_ready, complete); end
    endtask

    task automatic test_reset_mid_access();
        dest = 2'd2; alu_out = 16'h1122; is_8_bit = 1'b0; mem_addr = 16'h0101;
        alu_flags = 16'h00F0; flags_mask = 16'hFFFF; in_valid = 1'b1;
        tick();
        // in_valid stays high with different flags; must not be taken while busy.
        alu_flags = 16'hFF00;
        total++; if (flags !== 16'h00F2 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_capture got=%h %b exp=00F2 0", flags, in_ready); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if (mem_access !== 1'b1 || mem_address !== 15'h0081 || flags !== 16'h00F2)
            begin bad++; $display("FAIL mid_hi got=%b %h %h exp=1 0081 00F2", mem_access, mem_address, flags); end
        reset_n = 1'b0;
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        total++; if (mem_access !== 1'b0 || complete !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL mid_reset got=%b%b%b exp=001", mem_access, complete, in_ready); end
        total++; if (flags !== 16'h0002) begin bad++; $display("FAIL mid_reset_flags got=%h exp=0002", flags); end
        tick();
        total++; if (complete !== 1'b0 || mem_access !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL mid_after got=%b%b%b exp=001", complete, mem_access, in_ready); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; in_valid = 1'b0; alu_out = '0; alu_flags = '0;
        is_8_bit = 1'b0; flags_mask = '0; dest = '0; reg_sel = '0;
        mem_addr = '0; mem_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_reg_write();
        test_aligned_store();
        test_unaligned_store();
        test_odd_byte_store();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
